serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that performs a WIDTH-bit unsigned add with one shared 1-bit add cell. The 1-bit cell is a half adder pair plus carry flip-flop. The controller latches both operands on a start request, steps the cell through one bit per clock from LSB to MSB, then publishes sum and carry with a one-cycle done pulse. It sits beside the combinational adder blocks as the area-lean, multi-cycle alternative for wide operands.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to add `a` and `b`; honoured only in IDLE.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- carry_out  output  1  registered carry out of the MSB; holds like `sum`.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- States:
  - IDLE, reset state.
  - RUN.
  - DONE.
- IDLE, start=1:
  - Latch `a` and `b` into shift registers.
  - Clear the carry flip-flop.
  - Set bit counter cnt=0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE; no register changes.
- RUN, each edge:
  - First half adder: p = a_sh[0]^b_sh[0], g1 = a_sh[0]&b_sh[0].
  - Second half adder: s = p^c, g2 = p&c.
  - Next carry: c <= g1|g2.
  - Shift s into the result shift register at the MSB end (right shift).
  - Shift both operand registers right by one.
  - cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1: copy the completed result register to `sum`, the final carry to `carry_out`, then go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Go to IDLE on the next edge unconditionally.
- start while RUN or DONE: ignored, not queued; operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.
- Counter width: clog2(WIDTH)+1 bits; it never wraps within a run.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on `carry_out`.

## Timing
- Reset (asynchronous, effective immediately):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry_out=0, ovf=0.
  - Internal shift registers, carry and cnt are all cleared.
- Reset mid-run: abandons the operation; `sum` and `carry_out` return to 0, not their previous values.
- Latency: start accepted at edge E0 → `sum`/`carry_out` update at edge E(WIDTH) → done high during cycle E(WIDTH)..E(WIDTH+1).
- busy rises after E0 and falls after E(WIDTH+1).
- Throughput: one add per WIDTH+2 cycles; the earliest next accept is edge E(WIDTH+1)... more precisely, start must be sampled in IDLE, so the next accepting edge is E(WIDTH+2).
- WIDTH=1: a single RUN cycle; done is high in the cycle after E1.
- `sum` and `carry_out` change only at the completion edge or on reset; there are no intermediate glitches.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Port `ovf` exists.
  - At the completion edge, ovf <= (carry into MSB) ^ (carry out of MSB).
  - ovf holds like `sum`; it resets to 0.
- SERIAL_ADD_OVF_EN undefined:
  - Port `ovf` and its flip-flop are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, start pulse at E0 → busy 1 from E0; sum=8'h10, carry_out=0 at E8; done high for exactly one cycle after E8; busy low after E9.
- WIDTH=8, a=8'hFF, b=8'h01 → sum=8'h00, carry_out=1. Then a=8'hA5, b=8'h5A started at E10 → sum=8'hFF, carry_out=0.
- start held high continuously, a=8'h03, b=8'h04, operands changed to 8'hFF/8'hFF after E0 → result 8'h07; no restart until IDLE. The second add is accepted at E10.
- Assert rst at E4 of a run with a=8'h80, b=8'h80, previous sum=8'h10 → sum=0, carry_out=0, busy=0, done never pulses. A start after rst release runs normally.
- With SERIAL_ADD_OVF_EN, a=8'h7F, b=8'h01 → sum=8'h80, ovf=1, carry_out=0. With a=8'hFF, b=8'h01 → ovf=0, carry_out=1.
- WIDTH=1, a=1, b=1 → sum=0, carry_out=1, done in the cycle after E1. An exhaustive 4-case sweep matches the half-adder truth table.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit unsigned adder controller, one shared 1-bit add cell
// Optional signed overflow flag and ovf port enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             carry_out_q, carry_out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic p, g1, s, g2, c_next, last_bit;

   always_comb begin
      p        = a_sh_q[0] ^ b_sh_q[0];
      g1       = a_sh_q[0] & b_sh_q[0];
      s        = p ^ c_q;
      g2       = p & c_q;
      c_next   = g1 | g2;
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));

      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      sum_d       = sum_q;
      c_d         = c_q;
      carry_out_d = carry_out_q;
      cnt_d       = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d       = ovf_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               res_d   = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            c_d              = c_next;
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = s;
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            cnt_d            = cnt_q + 1'b1;
            if (last_bit) begin
               // res_d already holds the MSB produced on this edge
               sum_d       = res_d;
               carry_out_d = c_next;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d       = c_q ^ c_next;
`endif
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         c_q         <= 1'b0;
         carry_out_q <= 1'b0;
         cnt_q       <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         c_q         <= c_d;
         carry_out_q <= carry_out_d;
         cnt_q       <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances)
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf8, ovf1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf(ovf1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: phase counts edges since acceptance; result is plain a+b captured at accept.
   int         m8_phase = 0;
   logic [8:0] m8_pend  = '0;
   logic [7:0] m8_sum   = '0;
   logic       m8_c     = 1'b0;
   int         m1_phase = 0;
   logic [1:0] m1_pend  = '0;
   logic       m1_sum   = 1'b0;
   logic       m1_c     = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
   logic m8_ovf_p = 1'b0, m8_ovf = 1'b0, m1_ovf_p = 1'b0, m1_ovf = 1'b0;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m8_phase <= 0; m8_sum <= '0; m8_c <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         m8_ovf <= 1'b0;
`endif
      end else if (m8_phase == 0) begin
         if (start8) begin
            m8_pend  <= {1'b0, a8} + {1'b0, b8};
`ifdef SERIAL_ADD_OVF_EN
            m8_ovf_p <= ($signed(a8) + $signed(b8) > 127) || ($signed(a8) + $signed(b8) < -128);
`endif
            m8_phase <= 1;
         end
      end else if (m8_phase < 8) begin
         m8_phase <= m8_phase + 1;
      end else if (m8_phase == 8) begin
         {m8_c, m8_sum} <= m8_pend;
`ifdef SERIAL_ADD_OVF_EN
         m8_ovf <= m8_ovf_p;
`endif
         m8_phase <= 9;
      end else begin
         m8_phase <= 0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1_phase <= 0; m1_sum <= 1'b0; m1_c <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         m1_ovf <= 1'b0;
`endif
      end else if (m1_phase == 0) begin
         if (start1) begin
            m1_pend  <= {1'b0, a1} + {1'b0, b1};
`ifdef SERIAL_ADD_OVF_EN
            // 1-bit signed range is -1..0, so only -1 + -1 overflows
            m1_ovf_p <= a1[0] & b1[0];
`endif
            m1_phase <= 1;
         end
      end else if (m1_phase == 1) begin
         {m1_c, m1_sum} <= m1_pend;
`ifdef SERIAL_ADD_OVF_EN
         m1_ovf <= m1_ovf_p;
`endif
         m1_phase <= 2;
      end else begin
         m1_phase <= 0;
      end
   end

   always @(negedge clk) begin
      chk("busy8", busy8, m8_phase != 0);
      chk("done8", done8, m8_phase == 9);
      chk("sum8", sum8, m8_sum);
      chk("cout8", cout8, m8_c);
      chk("busy1", busy1, m1_phase != 0);
      chk("done1", done1, m1_phase == 2);
      chk("sum1", sum1, m1_sum);
      chk("cout1", cout1, m1_c);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf8", ovf8, m8_ovf);
      chk("ovf1", ovf1, m1_ovf);
`endif
   end

   task automatic wait_idle8();
      logic ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy8) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idle8_timeout", ok, 1);
   endtask

   task automatic wait_done8();
      logic ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done8) begin ok = 1'b1; break; end
      end
      chk("done8_seen", ok, 1);
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_sum, input logic exp_c, input logic exp_ovf);
      wait_idle8();
      start8 = 1'b1; a8 = av; b8 = bv;
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      chk("lit_busy8_after_accept", busy8, 1);
      wait_done8();
      chk("lit_sum8", sum8, exp_sum);
      chk("lit_cout8", cout8, exp_c);
`ifdef SERIAL_ADD_OVF_EN
      chk("lit_ovf8", ovf8, exp_ovf);
`else
      if (exp_ovf === 1'bx) chk("lit_ovf8_arg", exp_ovf, 0);
`endif
      @(negedge clk);
      chk("lit_done8_one_cycle", done8, 0);
      chk("lit_busy8_after_done", busy8, 0);
   endtask

   task automatic run1(input logic av, input logic bv, input logic [1:0] exp_cs);
      @(negedge clk);
      start1 = 1'b1; a1 = av; b1 = bv;
      @(posedge clk);
      #1;
      start1 = 1'b0; a1 = ~av; b1 = ~bv;
      @(negedge clk);
      chk("lit_done1_early", done1, 0);
      @(negedge clk);
      chk("lit_done1_after_e1", done1, 1);
      chk("lit_sum1", sum1, exp_cs[0]);
      chk("lit_cout1", cout1, exp_cs[1]);
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] tt [4];
      tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("lit_reset_sum8", sum8, 0);
      chk("lit_reset_busy8", busy8, 0);
      rst = 1'b0;

      run8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run8(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
      run8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

      // start held high: operands change after accept, second add only once idle again
      wait_idle8();
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h04;
      @(posedge clk);
      #1 a8 = 8'hFF; b8 = 8'hFF;
      wait_done8();
      chk("lit_held_sum8", sum8, 8'h07);
      chk("lit_held_cout8", cout8, 0);
      @(negedge clk);
      chk("lit_held_idle_gap", busy8, 0);
      @(posedge clk);
      #1 start8 = 1'b0;
      @(negedge clk);
      chk("lit_held_second_accept", busy8, 1);
      wait_done8();
      chk("lit_held2_sum8", sum8, 8'hFE);
      chk("lit_held2_cout8", cout8, 1);

      // reset in the middle of a run after a known previous result
      run8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      wait_idle8();
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_sum8", sum8, 0);
      chk("lit_rst_cout8", cout8, 0);
      chk("lit_rst_busy8", busy8, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("lit_rst_no_done", done8, 0);
      end
      run8(8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         logic [1:0] iv;
         iv = 2'(i);
         run1(iv[1], iv[0], tt[i]);
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
